// File: rtl/pio_pkg.sv
// Shared PIO definitions: register word addresses and edge-capture modes,
// common to the input and output PIO blocks.
package pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_DIR     = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  localparam int EDGE_FALL = 0;
  localparam int EDGE_RISE = 1;
  localparam int EDGE_ANY  = 2;

  // Per-bit edge events from current and one-cycle-delayed levels.
  function automatic logic [31:0] edge_events(input logic [31:0] cur,
                                               input logic [31:0] prev,
                                               input int          mode);
    case (mode)
      EDGE_FALL: edge_events = prev & ~cur;
      EDGE_RISE: edge_events = ~prev & cur;
      default:   edge_events = prev ^ cur;
    endcase
  endfunction

endpackage

// File: rtl/pio_debounce.sv
// One input bit: 2-flop synchroniser, hold-time debouncer, and a one-cycle
// delayed copy of the debounced level for edge detection.
module pio_debounce #(
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic dout_dly
);

  localparam int            CW   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          db_q, db_d;
  logic          dly_q, dly_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    dly_d   = db_q;
    db_d    = db_q;
    cnt_d   = '0;
    // Any return to the accepted level restarts the hold window.
    if (sync2_q != db_q) begin
      if (cnt_q == TERM) db_d  = sync2_q;
      else               cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= RESET_LEVEL;
      sync2_q <= RESET_LEVEL;
      db_q    <= RESET_LEVEL;
      dly_q   <= RESET_LEVEL;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      dly_q   <= dly_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout     = db_q;
  assign dout_dly = dly_q;

endmodule

// File: rtl/pio_key.sv
// Avalon-MM input PIO for keys/switches: debounced DATA, IRQMASK, sticky
// EDGECAPTURE (write-1-to-clear) and a registered level interrupt.
module pio_key
  import pio_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 500000,
  parameter int               EDGE_MODE       = EDGE_FALL,
  parameter logic [WIDTH-1:0] RESET_LEVEL     = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] db, db_dly;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_LEVEL    (RESET_LEVEL[i])
    ) u_db (
      .clk     (clk),
      .reset   (reset),
      .din     (in_port[i]),
      .dout    (db[i]),
      .dout_dly(db_dly[i])
    );
  end

  if (WIDTH < 32) begin : g_unused
    logic unused_wd;
    assign unused_wd = ^writedata[31:WIDTH];
  end

  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] ecap_q, ecap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;
  logic             wr;
  logic [WIDTH-1:0] clr, evt;
  logic [31:0]      evt_all;

  always_comb begin
    wr      = chipselect && !write_n;
    mask_d  = mask_q;
    clr     = '0;
    if (wr && address == PIO_ADDR_IRQMASK) mask_d = writedata[WIDTH-1:0];
    if (wr && address == PIO_ADDR_EDGECAP) clr    = writedata[WIDTH-1:0];
    evt_all = edge_events(32'(db), 32'(db_dly), EDGE_MODE);
    evt     = evt_all[WIDTH-1:0];
    // A new event outranks a same-cycle clear so no edge is lost.
    ecap_d  = (ecap_q & ~clr) | evt;
    irq_d   = |(ecap_q & mask_q);
    readdata_d = '0;
    case (address)
      PIO_ADDR_DATA:    readdata_d[WIDTH-1:0] = db;
      PIO_ADDR_IRQMASK: readdata_d[WIDTH-1:0] = mask_q;
      PIO_ADDR_EDGECAP: readdata_d[WIDTH-1:0] = ecap_q;
      default:          readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q     <= '0;
      ecap_q     <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      mask_q     <= mask_d;
      ecap_q     <= ecap_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_pio_key.sv
// Self-checking bench for pio_key: falling-edge instance and any-edge instance,
// register reads checked through a scoreboard queue.
module tb_pio_key;
  import pio_pkg::*;

  localparam int N = 8;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, cs, wn;
  logic [1:0]  addr;
  logic [31:0] wdata, rdata;
  logic [3:0]  pin;
  logic        irq;

  logic        b_reset, b_cs, b_wn;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata, b_rdata;
  logic [3:0]  b_pin;
  logic        b_irq;

  pio_key #(.WIDTH(4), .DEBOUNCE_CYCLES(N), .EDGE_MODE(EDGE_FALL), .RESET_LEVEL(4'hF)) dut (
    .clk(clk), .reset(reset), .address(addr), .chipselect(cs), .write_n(wn),
    .writedata(wdata), .in_port(pin), .readdata(rdata), .irq(irq));

  pio_key #(.WIDTH(4), .DEBOUNCE_CYCLES(N), .EDGE_MODE(EDGE_ANY), .RESET_LEVEL(4'hF)) dut2 (
    .clk(clk), .reset(b_reset), .address(b_addr), .chipselect(b_cs), .write_n(b_wn),
    .writedata(b_wdata), .in_port(b_pin), .readdata(b_rdata), .irq(b_irq));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic [1:0]  a;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t tbl[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present address, queue the expectation, compare one cycle later.
  task automatic rd(input bit u, input logic [1:0] a, input logic [31:0] exp, input string name);
    sb_t s;
    if (u) b_addr = a; else addr = a;
    sbq.push_back('{name, exp});
    tick();
    s = sbq.pop_front();
    check(s.name, u ? b_rdata : rdata, s.exp);
  endtask

  task automatic wr(input bit u, input logic [1:0] a, input logic [31:0] d);
    if (u) begin b_addr = a; b_cs = 1; b_wn = 0; b_wdata = d; end
    else   begin addr = a;   cs = 1;   wn = 0;   wdata = d;   end
    tick();
    if (u) begin b_cs = 0; b_wn = 1; end
    else   begin cs = 0;   wn = 1;   end
  endtask

  initial begin
    sb_t s;
    reset = 1; cs = 0; wn = 1; addr = 0; wdata = 0; pin = 4'hF;
    b_reset = 1; b_cs = 0; b_wn = 1; b_addr = 0; b_wdata = 0; b_pin = 4'hF;
    tbl[0] = '{2'd0, 32'h0000000F, "reset_data"};
    tbl[1] = '{2'd2, 32'h0,        "reset_mask"};
    tbl[2] = '{2'd3, 32'h0,        "reset_ecap"};
    tbl[3] = '{2'd1, 32'h0,        "reset_rsvd"};
    repeat (3) tick();
    reset = 0; b_reset = 0;

    for (int i = 0; i < 4; i++) rd(0, tbl[i].a, tbl[i].exp, tbl[i].name);
    check("reset_irq", 32'(irq), 32'h0);

    // Short glitch never reaches DATA nor EDGECAPTURE.
    pin = 4'hE;
    repeat (5) tick();
    pin = 4'hF;
    repeat (20) tick();
    rd(0, 2'd0, 32'hF, "glitch_data");
    rd(0, 2'd3, 32'h0, "glitch_ecap");

    wr(0, 2'd1, 32'hFFFF_FFFF);
    rd(0, 2'd1, 32'h0, "rsvd_write_ignored");
    wr(0, 2'd2, 32'h1);
    rd(0, 2'd2, 32'h1, "mask_rw");

    // Edge-by-edge timing: DATA at edge N+2, capture N+3, irq N+4.
    pin = 4'hE; addr = 2'd0;
    for (int k = 1; k <= N + 5; k++) begin
      sbq.push_back('{"timing_data", (k >= N + 3) ? 32'hE : 32'hF});
      sbq.push_back('{"timing_irq",  (k >= N + 4) ? 32'h1 : 32'h0});
      tick();
      s = sbq.pop_front(); check(s.name, rdata, s.exp);
      s = sbq.pop_front(); check(s.name, 32'(irq), s.exp);
    end
    rd(0, 2'd3, 32'h1, "ecap_set");

    wr(0, 2'd3, 32'h0);
    rd(0, 2'd3, 32'h1, "ecap_write0_keeps");
    check("irq_after_write0", 32'(irq), 32'h1);
    wr(0, 2'd3, 32'h1);
    check("irq_at_clear_edge", 32'(irq), 32'h1);
    tick();
    check("irq_after_clear", 32'(irq), 32'h0);
    rd(0, 2'd3, 32'h0, "ecap_cleared");

    // Falling edge on bit 2 captured in the very cycle it is being cleared.
    tick();
    pin = 4'hA;
    repeat (N + 2) tick();
    wr(0, 2'd3, 32'h4);
    rd(0, 2'd3, 32'h4, "set_beats_clear");
    rd(0, 2'd0, 32'hA, "data_a");
    check("irq_unmasked_bit", 32'(irq), 32'h0);

    wr(0, 2'd3, 32'h4);
    rd(0, 2'd3, 32'h0, "ecap_clear_bit2");
    pin = 4'hF;
    repeat (N + 6) tick();
    rd(0, 2'd0, 32'hF, "data_release");
    rd(0, 2'd3, 32'h0, "rise_ignored_fall_mode");

    // Any-edge instance: press and release both captured.
    b_pin = 4'hD;
    repeat (N + 6) tick();
    rd(1, 2'd0, 32'hD, "any_press_data");
    rd(1, 2'd3, 32'h2, "any_press_ecap");
    wr(1, 2'd3, 32'h2);
    rd(1, 2'd3, 32'h0, "any_clear");
    b_pin = 4'hF;
    repeat (N + 6) tick();
    rd(1, 2'd3, 32'h2, "any_release_ecap");
    wr(1, 2'd3, 32'h2);

    // Reset during a pending debounce discards it.
    b_pin = 4'hE;
    repeat (5) tick();
    b_reset = 1; b_pin = 4'hF;
    repeat (2) tick();
    b_reset = 0;
    repeat (N + 6) tick();
    rd(1, 2'd3, 32'h0, "rst_mid_ecap");
    rd(1, 2'd0, 32'hF, "rst_mid_data");
    check("rst_mid_irq", 32'(b_irq), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
